// File: rtl/lsu_perf_monitor.sv
// lsu_perf_monitor: passive per-channel OBI issue/stall/response/latency counters with registered readout
module lsu_perf_monitor #(
    parameter int NUM_CH          = 2,
    parameter int CNT_WIDTH       = 32,
    parameter int LAT_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        en_i,
    input  logic                                        clr_i,
    input  logic [NUM_CH-1:0]                           req_i,
    input  logic [NUM_CH-1:0]                           gnt_i,
    input  logic [NUM_CH-1:0]                           we_i,
    input  logic [NUM_CH-1:0]                           rvalid_i,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] rd_ch_i,
    input  logic [2:0]                                  rd_sel_i,
    output logic [CNT_WIDTH-1:0]                        rd_data_o,
    output logic [NUM_CH-1:0]                           ovf_o,
    output logic [NUM_CH-1:0]                           err_o
);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = CNT_WIDTH + LAT_WIDTH;

    // returns {clamped, saturated sum}
    function automatic logic [CNT_WIDTH:0] sat_add(input logic [CNT_WIDTH-1:0] a, input logic [LAT_WIDTH-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        return (s > SW'({CNT_WIDTH{1'b1}})) ? {1'b1, {CNT_WIDTH{1'b1}}} : {1'b0, s[CNT_WIDTH-1:0]};
    endfunction

    // next-state view of every statistic, so a read reflects the cycle it was sampled in
    logic [CNT_WIDTH-1:0] stat_d [NUM_CH][8];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [LAT_WIDTH-1:0] age_q [MAX_OUTSTANDING];
        logic [LAT_WIDTH-1:0] age_d [MAX_OUTSTANDING];
        logic [PW-1:0]        wp_q, wp_d, rp_q, rp_d;
        logic [OW-1:0]        oc_q, oc_d;
        logic [CNT_WIDTH-1:0] cnt_q [6];
        logic [CNT_WIDTH-1:0] cnt_d [6];
        logic [CNT_WIDTH:0]   r [6];
        logic [LAT_WIDTH-1:0] max_q, max_d, head;
        logic                 ovf_q, ovf_d, err_q, err_d;
        logic                 iss, pop, push, rv_err, push_err, upd, any_ovf;

        always_comb begin
            iss      = req_i[g] & gnt_i[g];
            pop      = rvalid_i[g] && oc_q != '0;
            rv_err   = rvalid_i[g] && oc_q == '0;
            push_err = iss && oc_q == OW'(MAX_OUTSTANDING) && !pop;
            push     = iss && !push_err;
            head     = age_q[rp_q];
            for (int i = 0; i < MAX_OUTSTANDING; i++)
                age_d[i] = (OW'(PW'(PW'(i) - rp_q)) < oc_q && age_q[i] != '1) ? age_q[i] + LAT_WIDTH'(1) : age_q[i];
            if (push)
                age_d[wp_q] = LAT_WIDTH'(1);
            wp_d = push ? (MAX_OUTSTANDING == 1 ? '0 : PW'(wp_q + PW'(1))) : wp_q;
            rp_d = pop ? (MAX_OUTSTANDING == 1 ? '0 : PW'(rp_q + PW'(1))) : rp_q;
            oc_d = oc_q + OW'(push) - OW'(pop);
            upd  = en_i && !clr_i;
            r[0] = sat_add(cnt_q[0], LAT_WIDTH'(push));
            r[1] = sat_add(cnt_q[1], LAT_WIDTH'(push && !we_i[g]));
            r[2] = sat_add(cnt_q[2], LAT_WIDTH'(push && we_i[g]));
            r[3] = sat_add(cnt_q[3], LAT_WIDTH'(push || oc_q != '0));
            r[4] = sat_add(cnt_q[4], LAT_WIDTH'(pop));
            r[5] = sat_add(cnt_q[5], pop ? head : '0);
            any_ovf = 1'b0;
            for (int k = 0; k < 6; k++) begin
                cnt_d[k] = clr_i ? '0 : upd ? r[k][CNT_WIDTH-1:0] : cnt_q[k];
                any_ovf  = any_ovf | r[k][CNT_WIDTH];
            end
            max_d = clr_i ? '0 : (upd && pop && head > max_q) ? head : max_q;
            ovf_d = clr_i ? 1'b0 : ovf_q | (upd & any_ovf);
            err_d = clr_i ? 1'b0 : err_q | rv_err | push_err;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < MAX_OUTSTANDING; i++)
                    age_q[i] <= '0;
                for (int k = 0; k < 6; k++)
                    cnt_q[k] <= '0;
                wp_q  <= '0;
                rp_q  <= '0;
                oc_q  <= '0;
                max_q <= '0;
                ovf_q <= 1'b0;
                err_q <= 1'b0;
            end else begin
                age_q <= age_d;
                cnt_q <= cnt_d;
                wp_q  <= wp_d;
                rp_q  <= rp_d;
                oc_q  <= oc_d;
                max_q <= max_d;
                ovf_q <= ovf_d;
                err_q <= err_d;
            end
        end

        for (genvar k = 0; k < 6; k++) begin : g_stat
            assign stat_d[g][k] = cnt_d[k];
        end
        assign stat_d[g][6] = CNT_WIDTH'(max_d);
        assign stat_d[g][7] = CNT_WIDTH'(oc_d);
        assign ovf_o[g]     = ovf_q;
        assign err_o[g]     = err_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            rd_data_o <= '0;
        else
            rd_data_o <= (int'(rd_ch_i) < NUM_CH) ? stat_d[rd_ch_i][rd_sel_i] : '0;
    end
endmodule

// File: tb/tb_lsu_perf_monitor.sv
// tb_lsu_perf_monitor: directed scenarios with a tagged scoreboard checked one cycle after each request
module tb_lsu_perf_monitor;
    localparam int NC = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          clr = 1'b0;
    logic [NC-1:0] req = '0, gnt = '0, we = '0, rvalid = '0;
    logic [NC-1:0] ovf, err;
    logic          rd_ch = 1'b0;
    logic [2:0]    rd_sel = '0;
    logic [CW-1:0] rd_data;

    typedef struct {
        int    tag;
        int    kind;
        int    idx;
        int    exp;
        string name;
    } chk_t;

    chk_t q[$];
    chk_t c;
    int   pcnt = 0;
    int   act;
    int   checks = 0;
    int   failures = 0;

    lsu_perf_monitor #(
        .NUM_CH(NC), .CNT_WIDTH(CW), .LAT_WIDTH(16), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
        .req_i(req), .gnt_i(gnt), .we_i(we), .rvalid_i(rvalid),
        .rd_ch_i(rd_ch), .rd_sel_i(rd_sel), .rd_data_o(rd_data),
        .ovf_o(ovf), .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcnt <= pcnt + 1;

    // kind 0: rd_data, 1: ovf bit, 2: err bit; each entry is due the cycle after it was queued
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tag == pcnt - 1) begin
            c   = q.pop_front();
            act = c.kind == 0 ? int'(rd_data) : c.kind == 1 ? int'(ovf[c.idx]) : int'(err[c.idx]);
            checks++;
            if (act != c.exp) begin
                failures++;
                $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
            end
        end
    end

    task automatic rq(input int ch, input int sel, input int exp, input string name);
        rd_ch  = ch[0];
        rd_sel = sel[2:0];
        q.push_back('{pcnt, 0, ch, exp, name});
    endtask

    task automatic fl(input int kind, input int idx, input int exp, input string name);
        q.push_back('{pcnt, kind, idx, exp, name});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        req = '0; gnt = '0; we = '0; rvalid = '0;
    endtask

    task automatic iss(input int ch, input bit w);
        req[ch] = 1'b1; gnt[ch] = 1'b1; we[ch] = w;
    endtask

    task automatic rv(input int ch);
        rvalid[ch] = 1'b1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    int e1[8] = '{1, 1, 0, 2, 1, 1, 1, 0};
    int e2[8] = '{3, 0, 3, 7, 3, 11, 4, 0};

    initial begin
        step();
        step();
        rst = 1'b0;
        fl(1, 0, 0, "rst_ovf0"); fl(2, 0, 0, "rst_err0");
        fl(1, 1, 0, "rst_ovf1"); fl(2, 1, 0, "rst_err1");
        for (int s = 0; s < 8; s++) begin
            rq(s % 2, s, 0, $sformatf("rst_ch%0d_sel%0d", s % 2, s));
            step();
        end
        en = 1'b1;
        // single read, latency 1
        iss(0, 0); step();
        rv(0); step();
        for (int s = 0; s < 8; s++) begin
            rq(0, s, e1[s], $sformatf("rd1_sel%0d", s));
            step();
        end
        fl(2, 0, 0, "rd1_err0"); step();
        pulse_clr();
        rq(0, 0, 0, "clr_issues"); step();
        rq(0, 6, 0, "clr_latmax"); step();
        // three pipelined writes, responses in cycles 3,5,6
        iss(0, 1); step();
        iss(0, 1); step();
        iss(0, 1); rq(0, 7, 3, "wr_oc_peak"); step();
        rv(0); step();
        step();
        rv(0); step();
        rv(0); step();
        for (int s = 0; s < 8; s++) begin
            rq(0, s, e2[s], $sformatf("wr3_sel%0d", s));
            step();
        end
        pulse_clr();
        // ch1 fills all slots then overissues
        repeat (4) begin
            iss(1, 0); step();
        end
        iss(1, 0); fl(2, 1, 1, "full_err1"); step();
        rq(1, 0, 4, "full_issues1"); step();
        rq(1, 7, 4, "full_oc1"); step();
        rq(0, 0, 0, "full_ch0_issues"); fl(2, 0, 0, "full_err0"); step();
        repeat (4) begin
            rv(1); step();
        end
        pulse_clr();
        // stray response
        rv(0); fl(2, 0, 1, "stray_err0"); step();
        rq(0, 4, 0, "stray_resp"); step();
        pulse_clr();
        fl(2, 0, 0, "clr_err0"); step();
        // saturation: 20 issues keeping one in flight
        iss(0, 0); step();
        repeat (19) begin
            iss(0, 0); rv(0); step();
        end
        rq(0, 0, 15, "sat_issues"); fl(1, 0, 1, "sat_ovf0"); step();
        pulse_clr();
        rq(0, 0, 0, "satclr_issues"); fl(1, 0, 0, "satclr_ovf0"); step();
        rq(0, 7, 1, "satclr_oc"); step();
        rv(0); step();
        rq(0, 4, 1, "satclr_resp"); step();
        // frozen statistics, live tracking
        en = 1'b0;
        repeat (5) begin
            iss(0, 1); rq(0, 7, 1, "frz_oc"); step();
            rv(0); step();
        end
        rq(0, 0, 0, "frz_issues"); step();
        rq(0, 4, 1, "frz_resp"); step();
        rq(0, 2, 0, "frz_writes"); step();
        en = 1'b1;
        // reset mid-transaction
        rv(1); fl(2, 1, 1, "pre_rst_err1"); step();
        iss(0, 0); step();
        rst = 1'b1; rq(0, 7, 0, "rst_rd"); fl(2, 1, 0, "rst_mid_err1"); fl(1, 0, 0, "rst_mid_ovf0"); step();
        checks++;
        if (rd_data != '0 || ovf != '0 || err != '0) begin
            failures++;
            $display("FAIL rst_direct: rd_data=%0d ovf=%b err=%b", rd_data, ovf, err);
        end
        rst = 1'b0;
        rq(0, 7, 0, "post_rst_oc"); step();
        rv(0); fl(2, 0, 1, "late_rv_err0"); step();
        repeat (3) step();
        while (q.size() > 0) begin
            c = q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: got none expected %0d", c.name, c.exp);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
